// File: rtl/trace_pkg.sv
// Shared types and entry layout for the write-back trace buffer.
// Entries are packed as {pc, data}, with the PC in the upper half.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      FROZEN  = 2'd3
   } trace_state_t;

   localparam int DATA_W_DEF = 32;
   localparam int ENTRY_W    = 2 * DATA_W_DEF;
   localparam int DATA_LSB   = 0;

   function automatic int entry_width(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int pc_lsb(input int data_w);
      return data_w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO used as the trace store.
// Full is judged before the pop, so a push into a full FIFO is always dropped.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers rely on DEPTH being a power of two to wrap for free.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_trace_buffer.sv
// Trigger-started trace capture of fetch PC and write-back data into a FWFT FIFO.
// Optional build macro TRACE_DEDUP_EN suppresses repeated PCs (pipeline stalls) during capture.
module wb_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DATA_W     = 32,
   parameter int POST_COUNT = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [DATA_W-1:0]        PC_In,
   input  logic [DATA_W-1:0]        WBData_In,
   input  logic [DATA_W-1:0]        Trigger_PC,
   input  logic                     Arm,
   input  logic                     Flush,
   output logic                     Out_Valid,
   input  logic                     Out_Ready,
   output logic [DATA_W-1:0]        Out_PC,
   output logic [DATA_W-1:0]        Out_Data,
   output logic [$clog2(DEPTH):0]   Fill_Count,
   output logic                     Overflow,
   output logic                     Done
);

   localparam int         EW        = entry_width(DATA_W);
   localparam int         PCL       = pc_lsb(DATA_W);
   localparam logic [7:0] POST_LAST = 8'(POST_COUNT);

   trace_state_t      state;
   trace_state_t      next_state;
   logic [7:0]        post_cnt;
   logic [7:0]        post_cnt_next;
   logic [DATA_W-1:0] last_pc;
   logic [DATA_W-1:0] last_pc_next;
   logic              wr_attempt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [EW-1:0]     wr_entry;
   logic [EW-1:0]     rd_entry;

   assign wr_entry[PCL +: DATA_W]      = PC_In;
   assign wr_entry[DATA_LSB +: DATA_W] = WBData_In;

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (Clock),
      .reset   (Reset),
      .push    (wr_attempt),
      .pop     (pop),
      .flush   (Flush),
      .wr_data (wr_entry),
      .rd_data (rd_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (Fill_Count)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         post_cnt <= '0;
         last_pc  <= '0;
      end else begin
         state    <= next_state;
         post_cnt <= post_cnt_next;
         last_pc  <= last_pc_next;
      end
   end

   // Arm always wins over a same-cycle trigger or capture write and restarts in ARMED.
   always_comb begin
      next_state    = state;
      post_cnt_next = post_cnt;
      last_pc_next  = last_pc;
      wr_attempt    = 1'b0;
      case (state)
         IDLE: begin
            if (Arm) begin
               next_state    = ARMED;
               post_cnt_next = '0;
            end
         end
         ARMED: begin
            if (Arm) begin
               post_cnt_next = '0;
            end else if (PC_In == Trigger_PC) begin
               wr_attempt    = 1'b1;
               post_cnt_next = 8'd1;
               last_pc_next  = PC_In;
               next_state    = (POST_LAST == 8'd1) ? FROZEN : CAPTURE;
            end
         end
         CAPTURE: begin
            if (Arm) begin
               next_state    = ARMED;
               post_cnt_next = '0;
            end else begin
`ifdef TRACE_DEDUP_EN
               if (PC_In != last_pc) begin
`else
               begin
`endif
                  wr_attempt    = 1'b1;
                  post_cnt_next = post_cnt + 8'd1;
                  last_pc_next  = PC_In;
                  if ((post_cnt + 8'd1) == POST_LAST) begin
                     next_state = FROZEN;
                  end
               end
            end
         end
         FROZEN: begin
            if (Arm) begin
               next_state    = ARMED;
               post_cnt_next = '0;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset || Arm) begin
         Overflow <= 1'b0;
      end else if (wr_attempt && fifo_full && !Flush) begin
         Overflow <= 1'b1;
      end
   end

   assign Out_Valid = !fifo_empty;
   assign pop       = Out_Valid && Out_Ready;
   assign Out_PC    = Out_Valid ? rd_entry[PCL +: DATA_W] : '0;
   assign Out_Data  = Out_Valid ? rd_entry[DATA_LSB +: DATA_W] : '0;
   assign Done      = (state == FROZEN);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: instance a uses POST_COUNT=8, instance b POST_COUNT=20.
// Expected stall behaviour follows TRACE_DEDUP_EN when the bench is built with it.
module tb_wb_trace_buffer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Arm;
   logic        Flush;
   logic        Out_Ready;
   logic [31:0] PC_In;
   logic [31:0] WBData_In;
   logic [31:0] Trigger_PC;

   logic        a_valid, a_ovf, a_done;
   logic [31:0] a_pc, a_data;
   logic [4:0]  a_fill;
   logic        b_valid, b_ovf, b_done;
   logic [31:0] b_pc, b_data;
   logic [4:0]  b_fill;

   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   wb_trace_buffer #(.DEPTH(16), .DATA_W(32), .POST_COUNT(8)) dut_a (
      .Clock(Clock), .Reset(Reset), .PC_In(PC_In), .WBData_In(WBData_In),
      .Trigger_PC(Trigger_PC), .Arm(Arm), .Flush(Flush), .Out_Valid(a_valid),
      .Out_Ready(Out_Ready), .Out_PC(a_pc), .Out_Data(a_data), .Fill_Count(a_fill),
      .Overflow(a_ovf), .Done(a_done)
   );

   wb_trace_buffer #(.DEPTH(16), .DATA_W(32), .POST_COUNT(20)) dut_b (
      .Clock(Clock), .Reset(Reset), .PC_In(PC_In), .WBData_In(WBData_In),
      .Trigger_PC(Trigger_PC), .Arm(Arm), .Flush(Flush), .Out_Valid(b_valid),
      .Out_Ready(Out_Ready), .Out_PC(b_pc), .Out_Data(b_data), .Fill_Count(b_fill),
      .Overflow(b_ovf), .Done(b_done)
   );

   typedef struct {
      logic        arm;
      logic [31:0] pc;
      logic [4:0]  fill;
      logic        done;
      logic        valid;
      logic [31:0] head;
   } vec_t;

   vec_t        vecs [15];
   logic [31:0] exp_stall [8];
   logic        exp_done_at8;

   function automatic vec_t mk(input logic arm, input logic [31:0] pc, input logic [4:0] fill,
                               input logic done, input logic valid, input logic [31:0] head);
      vec_t v;
      v.arm = arm; v.pc = pc; v.fill = fill; v.done = done; v.valid = valid; v.head = head;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are then sampled at the same point.
   task automatic applyStimulus(input logic arm, input logic [31:0] pc);
      Arm       = arm;
      PC_In     = pc;
      WBData_In = pc + 32'h1000;
      @(posedge Clock);
      #1;
   endtask

   task automatic doReset();
      Reset = 1'b1; Arm = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
      applyStimulus(1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0);
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0]  = mk(1'b1, 32'h38, 5'd0, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 32'h3C, 5'd0, 1'b0, 1'b0, 32'h0);
      vecs[2]  = mk(1'b0, 32'h40, 5'd1, 1'b0, 1'b1, 32'h40);
      vecs[3]  = mk(1'b0, 32'h44, 5'd2, 1'b0, 1'b1, 32'h40);
      vecs[4]  = mk(1'b0, 32'h48, 5'd3, 1'b0, 1'b1, 32'h40);
      vecs[5]  = mk(1'b0, 32'h4C, 5'd4, 1'b0, 1'b1, 32'h40);
      vecs[6]  = mk(1'b0, 32'h50, 5'd5, 1'b0, 1'b1, 32'h40);
      vecs[7]  = mk(1'b0, 32'h54, 5'd6, 1'b0, 1'b1, 32'h40);
      vecs[8]  = mk(1'b0, 32'h58, 5'd7, 1'b0, 1'b1, 32'h40);
      vecs[9]  = mk(1'b0, 32'h5C, 5'd8, 1'b1, 1'b1, 32'h40);
      vecs[10] = mk(1'b0, 32'h60, 5'd8, 1'b1, 1'b1, 32'h40);
      vecs[11] = mk(1'b0, 32'h64, 5'd8, 1'b1, 1'b1, 32'h40);
      vecs[12] = mk(1'b0, 32'h68, 5'd8, 1'b1, 1'b1, 32'h40);
      vecs[13] = mk(1'b0, 32'h6C, 5'd8, 1'b1, 1'b1, 32'h40);
      vecs[14] = mk(1'b0, 32'h70, 5'd8, 1'b1, 1'b1, 32'h40);

`ifdef TRACE_DEDUP_EN
      exp_stall = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C};
      exp_done_at8 = 1'b0;
`else
      exp_stall = '{32'h40, 32'h44, 32'h44, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54};
      exp_done_at8 = 1'b1;
`endif

      Trigger_PC = 32'h40;
      doReset();
      checkOutput("reset fill", 32'(a_fill), 32'd0);
      checkOutput("reset valid", 32'(a_valid), 32'd0);
      checkOutput("reset out_pc", a_pc, 32'h0);
      checkOutput("reset out_data", a_data, 32'h0);
      checkOutput("reset overflow", 32'(a_ovf), 32'd0);
      checkOutput("reset done", 32'(a_done), 32'd0);

      // Trigger walk with the sink stalled.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].arm, vecs[i].pc);
         checkOutput($sformatf("walk fill[%0d]", i), 32'(a_fill), 32'(vecs[i].fill));
         checkOutput($sformatf("walk done[%0d]", i), 32'(a_done), 32'(vecs[i].done));
         checkOutput($sformatf("walk valid[%0d]", i), 32'(a_valid), 32'(vecs[i].valid));
         checkOutput($sformatf("walk head[%0d]", i), a_pc, vecs[i].head);
      end
      checkOutput("walk overflow", 32'(a_ovf), 32'd0);

      // Drain in FROZEN.
      Out_Ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("drain pc[%0d]", i), a_pc, 32'h40 + 32'(4 * i));
         checkOutput($sformatf("drain data[%0d]", i), a_data, 32'h1040 + 32'(4 * i));
         applyStimulus(1'b0, 32'h200);
      end
      Out_Ready = 1'b0;
      checkOutput("drain valid", 32'(a_valid), 32'd0);
      checkOutput("drain fill", 32'(a_fill), 32'd0);
      checkOutput("drain done", 32'(a_done), 32'd1);

      // Reset in the middle of a capture.
      doReset();
      applyStimulus(1'b1, 32'h0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 32'h40 + 32'(4 * k));
      checkOutput("midcap fill", 32'(a_fill), 32'd5);
      Reset = 1'b1;
      applyStimulus(1'b0, 32'h54);
      Reset = 1'b0;
      checkOutput("midreset fill", 32'(a_fill), 32'd0);
      checkOutput("midreset valid", 32'(a_valid), 32'd0);
      checkOutput("midreset done", 32'(a_done), 32'd0);
      applyStimulus(1'b0, 32'h40);
      applyStimulus(1'b0, 32'h40);
      checkOutput("idle ignores trigger", 32'(a_fill), 32'd0);

      // Flush while FROZEN, then re-arm.
      applyStimulus(1'b1, 32'h0);
      for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h40 + 32'(4 * k));
      checkOutput("frozen done", 32'(a_done), 32'd1);
      checkOutput("frozen fill", 32'(a_fill), 32'd8);
      Flush = 1'b1;
      applyStimulus(1'b0, 32'h60);
      Flush = 1'b0;
      checkOutput("flush fill", 32'(a_fill), 32'd0);
      checkOutput("flush valid", 32'(a_valid), 32'd0);
      checkOutput("flush done", 32'(a_done), 32'd1);
      applyStimulus(1'b1, 32'h60);
      checkOutput("rearm done", 32'(a_done), 32'd0);
      applyStimulus(1'b0, 32'h40);
      checkOutput("rearm trigger fill", 32'(a_fill), 32'd1);

      // POST_COUNT=20 into a 16-deep FIFO.
      Trigger_PC = 32'h100;
      doReset();
      applyStimulus(1'b1, 32'h0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 32'h100 + 32'(4 * k));
         if (k == 15) begin
            checkOutput("ovf16 fill", 32'(b_fill), 32'd16);
            checkOutput("ovf16 overflow", 32'(b_ovf), 32'd0);
            checkOutput("ovf16 done", 32'(b_done), 32'd0);
         end
         if (k == 16) checkOutput("ovf17 overflow", 32'(b_ovf), 32'd1);
      end
      checkOutput("ovf fill", 32'(b_fill), 32'd16);
      checkOutput("ovf overflow", 32'(b_ovf), 32'd1);
      checkOutput("ovf done", 32'(b_done), 32'd1);
      Out_Ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("ovf drain pc[%0d]", i), b_pc, 32'h100 + 32'(4 * i));
         applyStimulus(1'b0, 32'h300);
      end
      Out_Ready = 1'b0;
      checkOutput("ovf drained valid", 32'(b_valid), 32'd0);

      // Push+pop while full during CAPTURE, then Arm clears Overflow.
      doReset();
      applyStimulus(1'b1, 32'h0);
      for (int k = 0; k < 16; k++) applyStimulus(1'b0, 32'h100 + 32'(4 * k));
      checkOutput("full fill", 32'(b_fill), 32'd16);
      Out_Ready = 1'b1;
      applyStimulus(1'b0, 32'h140);
      Out_Ready = 1'b0;
      checkOutput("fullpop fill", 32'(b_fill), 32'd15);
      checkOutput("fullpop overflow", 32'(b_ovf), 32'd1);
      checkOutput("fullpop done", 32'(b_done), 32'd0);
      checkOutput("fullpop head", b_pc, 32'h104);
      applyStimulus(1'b0, 32'h144);
      checkOutput("refill fill", 32'(b_fill), 32'd16);
      applyStimulus(1'b1, 32'h148);
      checkOutput("arm clears overflow", 32'(b_ovf), 32'd0);
      checkOutput("arm keeps fifo", 32'(b_fill), 32'd16);
      checkOutput("arm done", 32'(b_done), 32'd0);

      // PC stall during capture.
      Trigger_PC = 32'h40;
      doReset();
      applyStimulus(1'b1, 32'h0);
      applyStimulus(1'b0, 32'h40);
      applyStimulus(1'b0, 32'h44);
      applyStimulus(1'b0, 32'h44);
      applyStimulus(1'b0, 32'h44);
      applyStimulus(1'b0, 32'h48);
      applyStimulus(1'b0, 32'h4C);
      applyStimulus(1'b0, 32'h50);
      applyStimulus(1'b0, 32'h54);
      checkOutput("stall done@8", 32'(a_done), 32'(exp_done_at8));
      applyStimulus(1'b0, 32'h58);
      applyStimulus(1'b0, 32'h5C);
      checkOutput("stall done@10", 32'(a_done), 32'd1);
      checkOutput("stall fill", 32'(a_fill), 32'd8);
      Out_Ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("stall pc[%0d]", i), a_pc, exp_stall[i]);
         applyStimulus(1'b0, 32'h400);
      end
      Out_Ready = 1'b0;
      checkOutput("stall drained valid", 32'(a_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
